sram_req_arbiter: RTL and testbench

- Shares one sram-like memory port between the instruction-fetch requester (read-only) and the data requester (load/store).
- Sits between the pipeline stages and the bus bridge.
- Tracks outstanding transactions in issue order and routes each data_ok/rdata back to its owner.
- Downstream returns responses strictly in request order.

---
 rtl/cpu_bus_pkg.sv | 19 +
 rtl/arb_owner_fifo.sv | 62 ++++++
 rtl/sram_req_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared requester IDs, arbiter FSM encoding and size codes
package cpu_bus_pkg;

   // Owner IDs stored in the arbiter's owner FIFO
   localparam logic REQ_INST = 1'b0;
   localparam logic REQ_DATA = 1'b1;

   // Grant FSM encoding
   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   // sram-like transfer size codes
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/arb_owner_fifo.sv
// rtl/arb_owner_fifo.sv - 1-bit owner-ID FIFO tracking accepted-but-unanswered requests
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   push, din         enqueue owner ID din (ignored when full)
//   pop               dequeue head (ignored when empty)
//   head              owner ID of the oldest outstanding request
//   full, empty       occupancy flags from the registered count
//   count             number of outstanding entries, 0..DEPTH
module arb_owner_fifo #(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             din,
   input  logic             pop,
   output logic             head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] slots;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = slots[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         slots  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            slots[wr_ptr] <= din;
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one sram-like port between fetch and data requesters
//
// Optional macro SRAM_ARB_RR_EN: round-robin between simultaneous requests
// (default build: fixed data-over-inst priority).
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_req/inst_addr          fetch request (word read only)
//   inst_addr_ok/inst_data_ok   fetch accept / fetch response
//   data_req/wr/size/wstrb/addr/wdata   load/store request
//   data_addr_ok/data_data_ok   data accept / data response
//   rdata                       shared response data (mem_rdata passthrough)
//   mem_*                       downstream sram-like port
module sram_req_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   arb_state_e       state;
   arb_state_e       next_state;
   logic             lock_id;
   logic             grant_valid;
   logic             grant_id;
   logic             push;
   logic             pop;
   logic             head;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] occ;

`ifdef SRAM_ARB_RR_EN
   logic             last_grant;
`endif

   arb_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_owner_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .din    (grant_id),
      .pop    (pop),
      .head   (head),
      .full   (full),
      .empty  (empty),
      .count  (occ)
   );

   // Grant selection and downstream mux
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = REQ_DATA;
      next_state  = state;

      case (state)
         ARB_IDLE: begin
            // Full test uses the registered occupancy: a pop this cycle
            // does not free a slot until the next one.
            if (occ != CNT_W'(MAX_OUTSTANDING)) begin
               if (data_req && inst_req) begin
                  grant_valid = 1'b1;
`ifdef SRAM_ARB_RR_EN
                  grant_id    = ~last_grant;
`else
                  grant_id    = REQ_DATA;
`endif
               end else if (data_req) begin
                  grant_valid = 1'b1;
                  grant_id    = REQ_DATA;
               end else if (inst_req) begin
                  grant_valid = 1'b1;
                  grant_id    = REQ_INST;
               end
            end
            if (grant_valid && !mem_addr_ok) begin
               next_state = ARB_LOCK;
            end
         end
         ARB_LOCK: begin
            grant_valid = 1'b1;
            grant_id    = lock_id;
            if (mem_addr_ok) begin
               next_state = ARB_IDLE;
            end
         end
         default: next_state = ARB_IDLE;
      endcase

      // Combinational outputs must read 0 while reset is asserted
      if (!resetn) begin
         grant_valid = 1'b0;
      end

      mem_req   = grant_valid;
      mem_wr    = 1'b0;
      mem_size  = 2'b00;
      mem_wstrb = 4'b0000;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (grant_valid) begin
         if (grant_id == REQ_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
         end else begin
            mem_size  = SIZE_W;
            mem_addr  = inst_addr;
         end
      end
   end

   assign push         = mem_req & mem_addr_ok & ~full;
   assign pop          = resetn & mem_data_ok & ~empty;
   assign inst_addr_ok = mem_req & mem_addr_ok & (grant_id == REQ_INST);
   assign data_addr_ok = mem_req & mem_addr_ok & (grant_id == REQ_DATA);
   assign inst_data_ok = pop & (head == REQ_INST);
   assign data_data_ok = pop & (head == REQ_DATA);
   assign rdata        = mem_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ARB_IDLE;
         lock_id <= REQ_DATA;
      end else begin
         state <= next_state;
         if (state == ARB_IDLE && grant_valid && !mem_addr_ok) begin
            lock_id <= grant_id;
         end
      end
   end

`ifdef SRAM_ARB_RR_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_grant <= REQ_DATA;
      end else if (push) begin
         last_grant <= grant_id;
      end
   end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed table-driven bench for sram_req_arbiter
module tb_sram_req_arbiter;

   localparam logic [31:0] INA = 32'h1c00_0000;
   localparam logic [31:0] DA  = 32'h1c00_0100;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_req_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .rdata        (rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_wstrb    (mem_wstrb),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata)
   );

   typedef struct {
      logic        ir;
      logic        dr;
      logic        aok;
      logic        dok;
      logic [31:0] mrd;
      logic        e_req;
      logic [1:0]  e_size;
      logic [3:0]  e_wstrb;
      logic [31:0] e_addr;
      logic [3:0]  e_ok;   // {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic ir, input logic dr, input logic aok, input logic dok,
                               input logic [31:0] mrd, input int who, input logic [3:0] ok);
      vec_t v;
      v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.mrd = mrd; v.e_ok = ok;
      // who: 0 = no grant, 1 = inst granted, 2 = data granted (word load)
      v.e_req   = (who != 0);
      v.e_size  = (who != 0) ? 2'b10 : 2'b00;
      v.e_wstrb = (who == 2) ? 4'hf : 4'h0;
      v.e_addr  = (who == 1) ? INA : (who == 2) ? DA : 32'h0;
      return v;
   endfunction

   initial begin
      // single fetch, response two cycles later
      vecs[0]  = mk(1, 0, 1, 0, 32'h0,         1, 4'b1000);
      vecs[1]  = mk(0, 0, 0, 0, 32'h0,         0, 4'b0000);
      vecs[2]  = mk(0, 0, 0, 1, 32'h0280_0000, 0, 4'b0010);
      // simultaneous: data first, inst next; in-order responses routed
      vecs[3]  = mk(1, 1, 1, 0, 32'h0,         2, 4'b0100);
      vecs[4]  = mk(1, 0, 1, 0, 32'h0,         1, 4'b1000);
      vecs[5]  = mk(0, 0, 0, 1, 32'h1111_1111, 0, 4'b0001);
      vecs[6]  = mk(0, 0, 0, 1, 32'h2222_2222, 0, 4'b0010);
      // inst locked while data rises
      vecs[7]  = mk(1, 0, 0, 0, 32'h0,         1, 4'b0000);
      vecs[8]  = mk(1, 1, 0, 0, 32'h0,         1, 4'b0000);
      vecs[9]  = mk(1, 1, 0, 0, 32'h0,         1, 4'b0000);
      vecs[10] = mk(1, 1, 1, 0, 32'h0,         1, 4'b1000);
      vecs[11] = mk(0, 1, 1, 0, 32'h0,         2, 4'b0100);
      // full: no grant; pop while full does not grant the same cycle
      vecs[12] = mk(1, 1, 1, 0, 32'h0,         0, 4'b0000);
      vecs[13] = mk(1, 0, 1, 1, 32'h3333_3333, 0, 4'b0010);
      vecs[14] = mk(1, 0, 1, 0, 32'h0,         1, 4'b1000);
      vecs[15] = mk(0, 0, 0, 1, 32'h4444_4444, 0, 4'b0001);
      vecs[16] = mk(0, 0, 0, 1, 32'h5555_5555, 0, 4'b0010);
      // stray response with empty FIFO
      vecs[17] = mk(0, 0, 0, 1, 32'h6666_6666, 0, 4'b0000);

      inst_addr  = INA;
      data_addr  = DA;
      data_wr    = 1'b0;
      data_size  = 2'b10;
      data_wstrb = 4'hf;
      data_wdata = 32'h1234_5678;

      // reset state: everything 0 even with requests pending
      resetn      = 1'b0;
      inst_req    = 1'b1;
      data_req    = 1'b1;
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'hcafe_f00d;
      #3;
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_ok", {28'h0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'h0);
      check("rst_rdata", rdata, 32'hcafe_f00d);
      inst_req    = 1'b0;
      data_req    = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(posedge clk);
         #1;
         inst_req    = vecs[i].ir;
         data_req    = vecs[i].dr;
         mem_addr_ok = vecs[i].aok;
         mem_data_ok = vecs[i].dok;
         mem_rdata   = vecs[i].mrd;
         #4;
         check($sformatf("v%0d_mem_req", i), {31'h0, mem_req}, {31'h0, vecs[i].e_req});
         check($sformatf("v%0d_mem_wr", i), {31'h0, mem_wr}, 32'h0);
         check($sformatf("v%0d_mem_size", i), {30'h0, mem_size}, {30'h0, vecs[i].e_size});
         check($sformatf("v%0d_mem_wstrb", i), {28'h0, mem_wstrb}, {28'h0, vecs[i].e_wstrb});
         check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
         check($sformatf("v%0d_ok", i),
               {28'h0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
               {28'h0, vecs[i].e_ok});
         check($sformatf("v%0d_rdata", i), rdata, vecs[i].mrd);
      end

      // byte store: fields pass through exactly
      @(posedge clk);
      #1;
      inst_req    = 1'b0;
      data_req    = 1'b1;
      data_wr     = 1'b1;
      data_size   = 2'b00;
      data_wstrb  = 4'b0010;
      data_addr   = 32'h1c00_00f1;
      data_wdata  = 32'hdead_beef;
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b0;
      #4;
      check("st_mem_req", {31'h0, mem_req}, 32'h1);
      check("st_mem_wr", {31'h0, mem_wr}, 32'h1);
      check("st_mem_size", {30'h0, mem_size}, 32'h0);
      check("st_mem_wstrb", {28'h0, mem_wstrb}, 32'h2);
      check("st_mem_addr", mem_addr, 32'h1c00_00f1);
      check("st_mem_wdata", mem_wdata, 32'hdead_beef);
      check("st_addr_ok", {30'h0, inst_addr_ok, data_addr_ok}, 32'h1);
      @(posedge clk);
      #1;
      data_req    = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h0;
      #4;
      check("st_resp", {30'h0, inst_data_ok, data_data_ok}, 32'h1);

      // reset between accept and response
      @(posedge clk);
      #1;
      inst_req    = 1'b1;
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b0;
      #4;
      check("ra_inst_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
      @(posedge clk);
      #1;
      mem_addr_ok = 1'b0;
      #1;
      check("ra_mem_req_pre", {31'h0, mem_req}, 32'h1);
      resetn = 1'b0;
      #1;
      check("ra_mem_req_async", {31'h0, mem_req}, 32'h0);
      check("ra_mem_addr_async", mem_addr, 32'h0);
      inst_req = 1'b0;
      @(posedge clk);
      #2;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h0000_0055;
      #4;
      check("ra_stray_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
      check("ra_stray_rdata", rdata, 32'h0000_0055);
      @(posedge clk);
      #1;
      mem_data_ok = 1'b0;
      inst_req    = 1'b1;
      mem_addr_ok = 1'b1;
      #4;
      check("ra_regrant_addr", mem_addr, INA);
      check("ra_regrant_ok", {31'h0, inst_addr_ok}, 32'h1);
      @(posedge clk);
      #1;
      inst_req    = 1'b0;
      mem_addr_ok = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
